// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: takes one padded 512-bit block and streams W0..W(ROUNDS-1)
// through a 16-word sliding window, one word per output handshake.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_index,
  output logic         w_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state_r;
  state_t      state_s;
  logic        load_s;
  logic        shift_s;
  logic [31:0] win_r [16];
  logic [5:0]  count_r;
  logic [31:0] new_word_s;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  assign new_word_s = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];

  // Next-state and window-control decode
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (block_valid) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (w_ready) begin
          // The final word is left in win_r[0] so w_out keeps showing it while idle.
          if (count_r == LAST_IDX) begin
            state_s = IDLE;
          end else begin
            shift_s = 1'b1;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sliding 16-word window and round counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= 32'h0000_0000;
      end
      count_r <= 6'd0;
    end else if (load_s) begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= block_in[511 - 32*i -: 32];
      end
      count_r <= 6'd0;
    end else if (shift_s) begin
      for (int i = 0; i < 15; i++) begin
        win_r[i] <= win_r[i+1];
      end
      win_r[15] <= new_word_s;
      count_r   <= count_r + 6'd1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        win_r[i] <= win_r[i];
      end
      count_r <= count_r;
    end
  end

  assign block_ready = (state_r == IDLE);
  assign w_valid     = (state_r == RUN);
  assign w_out       = win_r[0];
  assign w_index     = count_r;
  assign w_last      = (state_r == RUN) && (count_r == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: reset, "abc" block, backpressure, back-to-back blocks,
// mid-block reset and a ROUNDS=16 build, checked against a plain software schedule model.
module tb_sha256_msg_schedule;

  logic         clock;
  logic         reset_n;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_in;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         w_last;

  logic         d16_block_valid;
  logic         d16_block_ready;
  logic [511:0] d16_block_in;
  logic         d16_w_valid;
  logic         d16_w_ready;
  logic [31:0]  d16_w_out;
  logic [5:0]   d16_w_index;
  logic         d16_w_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  exp_w   [64];
  logic [31:0]  obs_w   [64];
  logic [31:0]  obs_abc [64];
  logic [511:0] abc_blk;
  logic [511:0] blk_a;
  logic [511:0] blk_b;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_in    (block_in),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_out       (w_out),
    .w_index     (w_index),
    .w_last      (w_last)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clock       (clock),
    .reset_n     (reset_n),
    .block_valid (d16_block_valid),
    .block_ready (d16_block_ready),
    .block_in    (d16_block_in),
    .w_valid     (d16_w_valid),
    .w_ready     (d16_w_ready),
    .w_out       (d16_w_out),
    .w_index     (d16_w_index),
    .w_last      (d16_w_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic present_block(input logic [511:0] blk);
    int k;
    block_in    = blk;
    block_valid = 1'b1;
    k = 0;
    while (!block_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("accept_wait", {63'd0, block_ready}, 64'd1);
    @(negedge clock);
    block_valid = 1'b0;
    check("w0_latency", {63'd0, w_valid}, 64'd1);
  endtask

  // Consumes words idx 0..stop-1 of a ROUNDS=64 block, checking each against exp_w.
  task automatic collect(input int stop, input int stall_pct);
    int          idx;
    int          budget;
    bit          stalled;
    logic [31:0] prev_out;
    logic [5:0]  prev_idx;
    bit          rdy;
    idx = 0; budget = 0; stalled = 1'b0; prev_out = '0; prev_idx = '0;
    while (idx < stop && budget < 3000) begin
      if (w_valid) begin
        if (stalled) begin
          check("stall_out", {32'd0, w_out}, {32'd0, prev_out});
          check("stall_idx", {58'd0, w_index}, {58'd0, prev_idx});
        end
        check("w_index", {58'd0, w_index}, 64'(idx));
        check("w_out", {32'd0, w_out}, {32'd0, exp_w[idx]});
        check("w_last", {63'd0, w_last}, {63'd0, (idx == 63)});
        rdy      = ($urandom_range(99) >= stall_pct);
        w_ready  = rdy;
        stalled  = !rdy;
        prev_out = w_out;
        prev_idx = w_index;
        if (rdy) begin
          obs_w[idx] = w_out;
          idx++;
        end
      end else begin
        check("unexpected_idle", {63'd0, w_valid}, 64'd1);
        w_ready = 1'($urandom_range(1));
        stalled = 1'b0;
      end
      @(negedge clock);
      budget++;
    end
    if (idx < stop) check("collect_timeout", 64'(idx), 64'(stop));
    w_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; block_valid = 1'b1; w_ready = 1'b1; block_in = '0;
    d16_block_valid = 1'b0; d16_w_ready = 1'b0; d16_block_in = '0;
    abc_blk = {32'h6162_6380, 448'd0, 32'h0000_0018};
    block_in = abc_blk;

    // Reset held two cycles with a block offered
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("rst_w_valid", {63'd0, w_valid}, 64'd0);
      check("rst_w_out", {32'd0, w_out}, 64'd0);
      check("rst_w_index", {58'd0, w_index}, 64'd0);
      check("rst_w_last", {63'd0, w_last}, 64'd0);
    end
    reset_n = 1'b1;
    block_valid = 1'b0;
    check("rel_block_ready", {63'd0, block_ready}, 64'd1);
    check("rel_w_valid", {63'd0, w_valid}, 64'd0);
    @(negedge clock);
    check("idle_w_valid", {63'd0, w_valid}, 64'd0);

    // "abc" block, no stalls
    model(abc_blk);
    present_block(abc_blk);
    collect(64, 0);
    check("abc_ready_after_last", {63'd0, block_ready}, 64'd1);
    check("abc_valid_after_last", {63'd0, w_valid}, 64'd0);
    check("abc_hold_w63", {32'd0, w_out}, {32'd0, exp_w[63]});
    check("abc_w0", {32'd0, obs_w[0]}, 64'h6162_6380);
    check("abc_w15", {32'd0, obs_w[15]}, 64'h0000_0018);
    check("abc_w16", {32'd0, obs_w[16]}, 64'h6162_6380);
    check("abc_w17", {32'd0, obs_w[17]}, 64'h000F_0000);
    obs_abc = obs_w;

    // Same block under random backpressure
    present_block(abc_blk);
    collect(64, 30);
    check("bp_ready_after_last", {63'd0, block_ready}, 64'd1);
    for (int t = 0; t < 64; t++)
      if (obs_w[t] !== obs_abc[t]) check("bp_sequence", {32'd0, obs_w[t]}, {32'd0, obs_abc[t]});
    n_tests++;

    // Back-to-back random blocks with block_valid held high
    blk_a = rand_block();
    blk_b = rand_block();
    model(blk_a);
    block_in = blk_a;
    block_valid = 1'b1;
    @(negedge clock);
    check("b2b_a_w0", {63'd0, w_valid}, 64'd1);
    block_in = blk_b;
    collect(64, 0);
    check("b2b_gap_ready", {63'd0, block_ready}, 64'd1);
    check("b2b_gap_valid", {63'd0, w_valid}, 64'd0);
    @(negedge clock);
    block_valid = 1'b0;
    check("b2b_b_accept", {63'd0, w_valid}, 64'd1);
    check("b2b_b_index", {58'd0, w_index}, 64'd0);
    model(blk_b);
    collect(64, 0);
    check("b2b_end_ready", {63'd0, block_ready}, 64'd1);

    // Reset pulse after W20 is consumed
    blk_a = rand_block();
    model(blk_a);
    present_block(blk_a);
    collect(21, 20);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("mid_rst_valid", {63'd0, w_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, block_ready}, 64'd1);
    check("mid_rst_out", {32'd0, w_out}, 64'd0);
    @(negedge clock);
    check("mid_rst_stays_idle", {63'd0, w_valid}, 64'd0);
    blk_b = rand_block();
    model(blk_b);
    present_block(blk_b);
    collect(64, 0);
    check("post_rst_ready", {63'd0, block_ready}, 64'd1);

    // ROUNDS=16 build
    blk_a = rand_block();
    model(blk_a);
    d16_block_in = blk_a;
    d16_block_valid = 1'b1;
    check("r16_ready", {63'd0, d16_block_ready}, 64'd1);
    @(negedge clock);
    d16_block_valid = 1'b0;
    d16_w_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      check("r16_valid", {63'd0, d16_w_valid}, 64'd1);
      check("r16_index", {58'd0, d16_w_index}, 64'(t));
      check("r16_out", {32'd0, d16_w_out}, {32'd0, exp_w[t]});
      check("r16_last", {63'd0, d16_w_last}, {63'd0, (t == 15)});
      @(negedge clock);
    end
    check("r16_done_valid", {63'd0, d16_w_valid}, 64'd0);
    check("r16_done_ready", {63'd0, d16_block_ready}, 64'd1);
    check("r16_hold_w15", {32'd0, d16_w_out}, {32'd0, exp_w[15]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Iterative SHA-256 message-schedule generator sitting directly upstream of the compression datapath. Accepts one 512-bit padded message block over a valid/ready handshake and emits the 64 schedule words W0..W63, one per accepted output beat, in round order. It replaces the constant all-zero schedule with real message words and feeds the per-round `w_in` of the compression stage.

## Interface
- `ROUNDS`, 64: number of schedule words emitted per block; legal range 16..64.
- `clock` input 1: single clock, all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset; sampled on `clock`.
- `block_valid` input 1: upstream has a block on `block_in`.
- `block_ready` output 1: block accepted on the cycle where `block_valid && block_ready`.
- `block_in` input 512: padded message block, big-endian; W0 = `block_in[511:480]`, W15 = `block_in[31:0]`.
- `w_valid` output 1: `w_out` holds a valid schedule word.
- `w_ready` input 1: downstream consumes the word on `w_valid && w_ready`.
- `w_out` output 32: schedule word Wt.
- `w_index` output 6: t of the word on `w_out`.
- `w_last` output 1: high with `w_valid` when `w_index == ROUNDS-1`.

## Operation
- States: IDLE, RUN. Reset puts the FSM in IDLE.
- `block_ready = (state == IDLE)`. `w_valid = (state == RUN)`.
- IDLE, block handshake: load the 16-word window `win[0..15]` with W0..W15 from `block_in`, clear the counter to 0, go to RUN.
- RUN: `w_out = win[0]`, `w_index = counter`.
- RUN, output handshake, `counter != ROUNDS-1`:
  - Shift the window down: `win[i] <= win[i+1]`.
  - `win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0]`, mod 2^32.
  - `counter <= counter + 1`.
- RUN, output handshake, `counter == ROUNDS-1`: go to IDLE. The window does not shift, so `w_out` keeps showing W(ROUNDS-1) in IDLE.
- Schedule functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - All additions are 32-bit and wrap; carries are discarded.
- Backpressure: while `w_valid && !w_ready`, `w_out`, `w_index` and `w_last` stay stable.
- `block_valid` during RUN is ignored. `block_ready` is 0, so upstream must hold the block.

## Timing
- Reset (`reset_n` low at a rising edge):
  - Next cycle: state IDLE, `w_valid` 0, `w_last` 0, `w_index` 0, `w_out` 0 (window cleared), `block_ready` 1.
  - Reset has priority over any simultaneous handshake.
- Reset mid-block: the block is abandoned. `w_valid` is 0 on the following cycle and no further words from that block appear.
- Latency: block accepted at edge N → W0 with `w_valid` = 1 in the cycle after edge N.
- With `w_ready` held high, words are emitted at one per cycle. W(ROUNDS-1) is presented in the cycle after edge N+ROUNDS-1.
- Final output handshake at edge M:
  - IDLE and `block_ready` = 1 in the cycle after M.
  - The next block is accepted at the earliest at edge M+1, and its W0 appears in the cycle after M+1.
  - Cost: one bubble cycle per block; block period is ROUNDS+1 cycles at full throughput.
- Every `w_out` value comes directly from a register; no combinational path from `block_in` or `w_ready` to `w_out`.
- Combinational depth per cycle: one σ0, one σ1, and a 4-input 32-bit add.

## Test plan
- **Reset values:** assert `reset_n` low for 2 cycles while `block_valid` = 1.
  - During and after reset: `w_valid` 0, `w_out` 0, `w_index` 0.
  - First cycle after release: `block_ready` 1.
  - No block is accepted during reset.
- **"abc" block:** `block_in` = 0x61626380, 14 × 0x00000000, 0x00000018; `w_ready` held 1.
  - W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000.
  - All 64 words match a software model.
  - `w_last` is high only with `w_index` = 63.
  - `block_ready` returns the cycle after the W63 handshake.
- **Backpressure:** same block with `w_ready` random at 30%.
  - `w_out` and `w_index` are stable whenever `w_valid && !w_ready`.
  - The word sequence is identical to the unstalled run.
- **Back-to-back blocks:** two random blocks with `block_valid` held high.
  - Second block is accepted exactly one cycle after the first block's W63 handshake.
  - 128 words total, each matching the model.
  - `block_valid` during RUN does not disturb the output.
- **Mid-block reset:** pulse `reset_n` low for 1 cycle after W20 is consumed.
  - `w_valid` is 0 on the next cycle and the FSM is in IDLE.
  - A new block then produces a correct W0..W63.
- **`ROUNDS` = 16 build:** emits exactly W0..W15 from `block_in`, with `w_last` at `w_index` 15.
